// File: rtl/rptr_empty_pkg.sv
// ============================================================================
// rptr_empty_pkg : shared FIFO pointer helpers (Gray/binary conversion, depth)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package rptr_empty_pkg;

    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic ptr_word_t width_mask(input int w);
        if (w >= PTR_MAX_W)
            return '1;
        return (ptr_word_t'(1) << w) - ptr_word_t'(1);
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b, input int w);
        ptr_word_t bm;
        bm = b & width_mask(w);
        return (bm >> 1) ^ bm;
    endfunction

    // Prefix XOR via doubling shifts covers every width up to PTR_MAX_W.
    function automatic ptr_word_t gray2bin(input ptr_word_t g, input int w);
        ptr_word_t b;
        b = g & width_mask(w);
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        return b & width_mask(w);
    endfunction

endpackage : rptr_empty_pkg

`default_nettype wire

// File: rtl/rptr_empty_if.sv
// ============================================================================
// rptr_empty_if : read-side pointer bus; almost-empty field with RPTR_ALMOST_EMPTY_EN
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface rptr_empty_if #(
    parameter int ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;
`ifdef RPTR_ALMOST_EMPTY_EN
    logic                ralmost_empty;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, rlevel, runderflow, ralmost_empty
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, rlevel, runderflow, ralmost_empty
    );
`else
    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, rlevel, runderflow
    );
`endif
endinterface : rptr_empty_if

`default_nettype wire

// File: rtl/rptr_empty_gray2bin_dec.sv
// ============================================================================
// gray2bin_dec : combinational Gray-to-binary decoder (XOR prefix per bit)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module gray2bin_dec #(
    parameter int W = 5
) (
    input  wire logic [W-1:0] gray,
    output logic      [W-1:0] bin
);

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign bin[i] = ^gray[W-1:i];
        end
    endgenerate

endmodule : gray2bin_dec

`default_nettype wire

// File: rtl/rptr_empty.sv
// ============================================================================
// rptr_empty : read pointer, empty flag, fill level and underflow for async FIFO
// Optional almost-empty output when RPTR_ALMOST_EMPTY_EN is defined.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 2
) (
    input wire logic   rclk,
    input wire logic   rrst_n,
    rptr_empty_if.slave bus
);

    localparam int PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rgray;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] level_next;
    logic [ADDRSIZE:0] rlevel_reg;
    logic              rempty_reg;
    logic              runder_reg;
    logic              rd_en;

    assign rd_en      = bus.rinc & ~rempty_reg;
    assign rbinnext   = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgraynext  = PW'(bin2gray(ptr_word_t'(rbinnext), PW));
    assign level_next = wbin_s - rbinnext;

    gray2bin_dec #(
        .W (PW)
    ) u_wdec (
        .gray (bus.rq2_wptr),
        .bin  (wbin_s)
    );

    // Empty compares the next Gray pointer so the final read flags empty on its own edge.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rgray      <= '0;
            rempty_reg <= 1'b1;
            rlevel_reg <= '0;
            runder_reg <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rgray      <= rgraynext;
            rempty_reg <= (rgraynext == bus.rq2_wptr);
            rlevel_reg <= level_next;
            runder_reg <= bus.rinc & rempty_reg;
        end
    end

    assign bus.raddr      = rbin[ADDRSIZE-1:0];
    assign bus.rptr       = rgray;
    assign bus.rempty     = rempty_reg;
    assign bus.rlevel     = rlevel_reg;
    assign bus.runderflow = runder_reg;

`ifdef RPTR_ALMOST_EMPTY_EN
    localparam logic [ADDRSIZE:0] AE_THRESH = PW'(AE_LEVEL);

    logic rae_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            rae_reg <= 1'b1;
        else
            rae_reg <= (level_next <= AE_THRESH);
    end

    assign bus.ralmost_empty = rae_reg;
`else
    // AE_LEVEL has no effect without the almost-empty option.
    if (AE_LEVEL < 0) begin : g_ae_ignored
    end
`endif

endmodule : rptr_empty

`default_nettype wire
